mem_bus_responder: RTL and testbench
====================================

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte/word address width of command_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, word width; line width LINE_BITS = DATA_WIDTH*2**OFFSET_LENGTH.
REQ-003 SHALL have parameter OFFSET_LENGTH, default 5, address bits selecting a word within a line.
REQ-004 SHALL have parameter MEM_INDEX_LENGTH, default 8, backing store holds 2**MEM_INDEX_LENGTH lines.
REQ-005 SHALL have parameter LATENCY, default 4, legal range >= 1, busy cycles per command.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous active-low reset (0 = in reset).
REQ-008 SHALL have port command_valid  input  1  requester holds a command.
REQ-009 SHALL have port command_store  input  1  1 = line store, 0 = line load.
REQ-010 SHALL have port command_rready  input  1  requester accepts load data.
REQ-011 SHALL have port command_addr  input  ADDR_WIDTH  line address.
REQ-012 SHALL have port data_to_bus  input  LINE_BITS  store line data.
REQ-013 SHALL have port bus_ready  output  1  one-cycle command-retire pulse.
REQ-014 SHALL have port bus_valid  output  1  load data valid.
REQ-015 SHALL have port data_from_bus  output  LINE_BITS  load line data.

Function
REQ-016 SHALL implement states IDLE, BUSY, RESP.
REQ-017 In IDLE with command_valid=1 (cycle 0), SHALL capture command_addr, command_store, data_to_bus and enter BUSY with latency counter = LATENCY.
REQ-018 SHALL decrement the counter each BUSY cycle; bus_ready SHALL be 1 only in the BUSY cycle where counter == 1 (cycle LATENCY), else 0.
REQ-019 Store: captured line SHALL be written at the end of cycle LATENCY; next state IDLE.
REQ-020 Load: at end of cycle LATENCY SHALL latch the addressed line into data_from_bus and enter RESP; bus_valid=1 from cycle LATENCY+1.
REQ-021 In RESP, bus_valid and data_from_bus SHALL hold stable until command_rready=1; that cycle completes, next state IDLE.
REQ-022 Line index = command_addr[OFFSET_LENGTH+MEM_INDEX_LENGTH-1 : OFFSET_LENGTH]; offset bits SHALL be ignored.
REQ-023 Inputs changing during BUSY/RESP SHALL be ignored; only captured values used.
REQ-024 command_valid still high in the IDLE cycle after completion SHALL be accepted as a new command (back-to-back, no bubble beyond that IDLE cycle).
REQ-025 bus_valid SHALL be 0 in IDLE and BUSY; data_from_bus SHALL retain last load value outside RESP.
REQ-026 At most one outstanding command; bus_ready and bus_valid SHALL never be 1 in the same cycle.

Reset
REQ-027 reset=0 at a rising edge SHALL force IDLE, counter 0, bus_ready=0, bus_valid=0, data_from_bus=0, all memory lines 0.
REQ-028 Reset during BUSY or RESP SHALL abort the command; a pending store SHALL NOT be written.

Configuration
REQ-029 Macro MEM_BUS_ADDR_CHECK_EN defined: command_addr bits above OFFSET_LENGTH+MEM_INDEX_LENGTH-1 nonzero SHALL make a store a no-write (bus_ready timing unchanged) and a load return all-ones.
REQ-030 Macro undefined: upper address bits SHALL be ignored (addresses alias onto index), no extra logic.

Verification
REQ-031 Reset held 2 cycles -> bus_ready=0, bus_valid=0, data_from_bus=0; load of addr 0x40 then returns all-zero line.
REQ-032 Store addr 0x40 (index 2), data all 0xA5 bytes, LATENCY=4 -> bus_ready=1 exactly in cycle 4, IDLE in cycle 5.
REQ-033 Load addr 0x5F after REQ-032 -> bus_ready cycle 4, bus_valid from cycle 5 with all-0xA5 line; command_rready=0 for 3 cycles -> data stable; rready=1 cycle 8 -> IDLE cycle 9.
REQ-034 Back-to-back store 0x20 then load 0x20 with command_valid held -> second accept in IDLE cycle 5, load data equals stored data.
REQ-035 reset=0 in BUSY cycle 2 of store to 0x60 -> IDLE next cycle, no bus_ready, later load of 0x60 returns zeros.
REQ-036 Store all 0x3C at 0x0, then load 0x2000 -> macro defined: all-ones; undefined: all-0x3C (aliased index 0).

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: single-outstanding line load/store responder with a
// fixed busy latency per command and a line-wide backing store.
// Optional feature: define MEM_BUS_ADDR_CHECK_EN so that addresses with bits
// set above the line index make stores a no-write and loads return all-ones.
module mem_bus_responder #(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int OFFSET_LENGTH    = 5,
  parameter int MEM_INDEX_LENGTH = 8,
  parameter int LATENCY          = 4,
  localparam int LINE_BITS       = DATA_WIDTH * (2 ** OFFSET_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  command_valid,
  input  logic                  command_store,
  input  logic                  command_rready,
  input  logic [ADDR_WIDTH-1:0] command_addr,
  input  logic [LINE_BITS-1:0]  data_to_bus,
  output logic                  bus_ready,
  output logic                  bus_valid,
  output logic [LINE_BITS-1:0]  data_from_bus
);

  localparam int MEM_LINES = 2 ** MEM_INDEX_LENGTH;
  localparam int IDX_LO    = OFFSET_LENGTH;
  localparam int IDX_HI    = OFFSET_LENGTH + MEM_INDEX_LENGTH - 1;
  localparam int CNT_W     = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [CNT_W-1:0]            cnt;
  logic                        cap_store;
  logic [MEM_INDEX_LENGTH-1:0] cap_index;
  logic [LINE_BITS-1:0]        cap_data;
  logic                        cap_oob;
  logic                        addr_oob;
  logic                        accept;
  logic                        retire;
  logic                        addr_bits_unused;
  logic [LINE_BITS-1:0]        line_rd [MEM_LINES];

  // A command is taken only from IDLE; it retires in the last busy cycle.
  assign accept = (state == IDLE) && command_valid;
  assign retire = (state == BUSY) && (cnt == CNT_W'(1));

  // Offset bits (and upper bits when unchecked) deliberately play no role.
  assign addr_bits_unused = ^command_addr;

`ifdef MEM_BUS_ADDR_CHECK_EN
  assign addr_oob = |(command_addr >> (IDX_HI + 1));
`else
  assign addr_oob = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: stores return to IDLE on retire, loads wait in RESP for rready
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (command_valid) state_next = BUSY;
      BUSY:    if (cnt == CNT_W'(1)) state_next = cap_store ? IDLE : RESP;
      RESP:    if (command_rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: retire pulse in the final busy cycle, load data valid only in RESP
  always_comb begin
    bus_ready = retire;
    bus_valid = (state == RESP);
  end

  // Latency counter: loaded on accept, counts down through BUSY
  always_ff @(posedge clk) begin
    if (!reset)              cnt <= '0;
    else if (accept)         cnt <= CNT_W'(LATENCY);
    else if (state == BUSY)  cnt <= cnt - CNT_W'(1);
  end

  // Command capture: later changes on the request inputs are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_store <= command_store;
      cap_index <= command_addr[IDX_HI:IDX_LO];
      cap_data  <= data_to_bus;
      cap_oob   <= addr_oob;
    end
  end

  for (genvar g = 0; g < MEM_LINES; g++) begin : g_line
    logic [LINE_BITS-1:0] line_q;
    logic                 line_we;

    assign line_we = retire && cap_store && !cap_oob &&
                     (cap_index == MEM_INDEX_LENGTH'(g));

    // Line storage: cleared by reset, written only when a store retires here
    always_ff @(posedge clk) begin
      if (!reset)       line_q <= '0;
      else if (line_we) line_q <= cap_data;
    end

    assign line_rd[g] = line_q;
  end

  // Load data register: captured on load retire, held until the next load
  always_ff @(posedge clk) begin
    if (!reset)                     data_from_bus <= '0;
    else if (retire && !cap_store)  data_from_bus <= cap_oob ? '1 : line_rd[cap_index];
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: expected load lines are queued at
// issue time from a small line model and popped when bus_valid appears.
module tb_mem_bus_responder;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int OL  = 5;
  localparam int IL  = 8;
  localparam int LAT = 4;
  localparam int LB  = DW * (2 ** OL);
  localparam int NL  = 2 ** IL;

  logic          clk = 1'b0;
  logic          reset;
  logic          command_valid;
  logic          command_store;
  logic          command_rready;
  logic [AW-1:0] command_addr;
  logic [LB-1:0] data_to_bus;
  logic          bus_ready;
  logic          bus_valid;
  logic [LB-1:0] data_from_bus;

  int            total = 0;
  int            bad   = 0;
  logic          mon_en = 1'b0;
  logic [LB-1:0] model [NL];
  logic [LB-1:0] sb_q [$];

  mem_bus_responder #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .OFFSET_LENGTH    (OL),
    .MEM_INDEX_LENGTH (IL),
    .LATENCY          (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .command_valid  (command_valid),
    .command_store  (command_store),
    .command_rready (command_rready),
    .command_addr   (command_addr),
    .data_to_bus    (data_to_bus),
    .bus_ready      (bus_ready),
    .bus_valid      (bus_valid),
    .data_from_bus  (data_from_bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (low 64 bits shown)", tag, got[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] r;
    for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [IL-1:0] idx_of(input logic [AW-1:0] a);
    return a[OL+IL-1:OL];
  endfunction

  function automatic logic [LB-1:0] exp_load(input logic [AW-1:0] a);
`ifdef MEM_BUS_ADDR_CHECK_EN
    if ((a >> (OL + IL)) != '0) return '1;
`endif
    return model[idx_of(a)];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NL; i++) model[i] = '0;
  endtask

  // Present a command; the model and scoreboard are updated here.
  task automatic issue(input logic st, input logic [AW-1:0] a, input logic [LB-1:0] d);
    command_valid = 1'b1;
    command_store = st;
    command_addr  = a;
    data_to_bus   = d;
    if (st) begin
`ifdef MEM_BUS_ADDR_CHECK_EN
      if ((a >> (OL + IL)) == '0) model[idx_of(a)] = d;
`else
      model[idx_of(a)] = d;
`endif
    end else begin
      sb_q.push_back(exp_load(a));
    end
  endtask

  // Walk one accepted command from cycle 0 to its completion.
  task automatic complete(input logic st, input int rdelay, input logic chain,
                          input logic nst, input logic [AW-1:0] na, input logic [LB-1:0] nd);
    logic [LB-1:0] exp;
    check_val("ready_c0", LB'(bus_ready), '0);
    for (int c = 1; c <= LAT; c++) begin
      step();
      if (c == 1) begin
        if (chain) issue(nst, na, nd);
        else begin
          command_valid = 1'b0;
          command_store = 1'($urandom);
          command_addr  = {$urandom, $urandom};
          data_to_bus   = rand_line();
        end
        command_rready = 1'($urandom);
      end
      if (c == LAT) command_rready = (rdelay == 0);
      check_val($sformatf("ready_c%0d", c), LB'(bus_ready), LB'(c == LAT));
      check_val($sformatf("valid_busy_c%0d", c), LB'(bus_valid), '0);
    end
    step();
    if (st) begin
      check_val("ready_after_store", LB'(bus_ready), '0);
      check_val("valid_after_store", LB'(bus_valid), '0);
    end else begin
      exp = '0;
      if (sb_q.size() == 0) check_val("sb_depth", LB'(sb_q.size()), LB'(1));
      else exp = sb_q.pop_front();
      check_val("valid_resp", LB'(bus_valid), LB'(1));
      check_val("ready_resp", LB'(bus_ready), '0);
      check_val("data_resp", data_from_bus, exp);
      for (int i = 0; i < rdelay; i++) begin
        step();
        check_val("valid_hold", LB'(bus_valid), LB'(1));
        check_val("data_hold", data_from_bus, exp);
        if (i == rdelay - 1) command_rready = 1'b1;
      end
      step();
      command_rready = 1'b0;
      check_val("valid_idle", LB'(bus_valid), '0);
      check_val("data_retain", data_from_bus, exp);
    end
  endtask

  // bus_ready and bus_valid must never coincide
  always @(negedge clk) begin
    if (mon_en) check_val("excl", LB'(bus_ready & bus_valid), '0);
  end

  initial begin
    logic [LB-1:0] d;
    logic [AW-1:0] a;
    logic          st;

    reset          = 1'b0;
    command_valid  = 1'b0;
    command_store  = 1'b0;
    command_rready = 1'b0;
    command_addr   = '0;
    data_to_bus    = '0;
    clear_model();

    step();
    step();
    check_val("rst_ready", LB'(bus_ready), '0);
    check_val("rst_valid", LB'(bus_valid), '0);
    check_val("rst_data", data_from_bus, '0);
    reset  = 1'b1;
    mon_en = 1'b1;
    step();

    issue(1'b0, 64'h40, '0);
    complete(1'b0, 0, 1'b0, 1'b0, '0, '0);

    issue(1'b1, 64'h40, {(LB/8){8'hA5}});
    complete(1'b1, 0, 1'b0, 1'b0, '0, '0);

    issue(1'b0, 64'h5F, '0);
    complete(1'b0, 3, 1'b0, 1'b0, '0, '0);

    d = rand_line();
    issue(1'b1, 64'h20, d);
    complete(1'b1, 0, 1'b1, 1'b0, 64'h20, rand_line());
    complete(1'b0, 1, 1'b0, 1'b0, '0, '0);

    for (int n = 0; n < 12; n++) begin
      a = {$urandom, $urandom};
      a[OL+IL-1:OL] = IL'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a[AW-1:OL+IL] = '0;
      st = 1'($urandom);
      issue(st, a, rand_line());
      complete(st, $urandom_range(0, 2), 1'b0, 1'b0, '0, '0);
    end

    // store to 0x60 aborted by reset in busy cycle 2
    command_valid = 1'b1;
    command_store = 1'b1;
    command_addr  = 64'h60;
    data_to_bus   = rand_line();
    check_val("abort_ready_c0", LB'(bus_ready), '0);
    step();
    command_valid = 1'b0;
    step();
    check_val("abort_ready_c2", LB'(bus_ready), '0);
    reset = 1'b0;
    step();
    check_val("abort_ready_c3", LB'(bus_ready), '0);
    check_val("abort_valid_c3", LB'(bus_valid), '0);
    check_val("abort_data_c3", data_from_bus, '0);
    clear_model();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("abort_no_ready", LB'(bus_ready), '0);
    end

    issue(1'b0, 64'h60, '0);
    complete(1'b0, 0, 1'b0, 1'b0, '0, '0);
    issue(1'b0, 64'h40, '0);
    complete(1'b0, 0, 1'b0, 1'b0, '0, '0);

    issue(1'b1, 64'h0, {(LB/8){8'h3C}});
    complete(1'b1, 0, 1'b0, 1'b0, '0, '0);
    issue(1'b0, 64'h2000, '0);
    complete(1'b0, 1, 1'b0, 1'b0, '0, '0);

    step();
    check_val("sb_drained", LB'(sb_q.size()), '0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
